mem_port_arbiter: RTL and testbench

// - Two-requester arbiter/sequencer in front of memctrl; shares one memctrl between instr-fetch (IF, read-only) and load/store (LS, read/write).
// - Accepts one transaction at a time, issues a 1-cycle command pulse to memctrl, holds addr/data stable until memctrl completes, and returns the response to the owner.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS arbiter and sequencer sharing one memctrl port
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed LS > IF priority.
module mem_port_arbiter #(
  parameter  int RAM_WIDTH = 18,
  parameter  int RAM_DEPTH = 1024,
  localparam int ADDR_W    = $clog2(RAM_DEPTH - 1)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,

  input  logic                 if_req_i,
  input  logic [ADDR_W-1:0]    if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rsp_valid_o,
  output logic [RAM_WIDTH-1:0] if_rsp_data_o,

  input  logic                 ls_req_i,
  input  logic                 ls_we_i,
  input  logic [ADDR_W-1:0]    ls_addr_i,
  input  logic [RAM_WIDTH-1:0] ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_rsp_valid_o,
  output logic [RAM_WIDTH-1:0] ls_rsp_data_o,

  output logic                 mc_rd_o,
  output logic                 mc_wr_o,
  output logic [ADDR_W-1:0]    mc_raddr_o,
  output logic [ADDR_W-1:0]    mc_waddr_o,
  output logic [RAM_WIDTH-1:0] mc_wr_data_o,
  input  logic [RAM_WIDTH-1:0] mc_rd_data_i,
  input  logic                 mc_rd_valid_i,
  input  logic                 mc_wr_done_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   owner_ls_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [RAM_WIDTH-1:0]   wdata_q;
  logic [RAM_WIDTH-1:0]   if_rsp_data_q;
  logic [RAM_WIDTH-1:0]   ls_rsp_data_q;
  logic                   if_win, ls_win;
  logic                   txn_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // prio_ls_q = 1 means LS wins the next contention; flips to the requester not just served.
  logic prio_ls_q;

  always_comb begin
    ls_win = ls_req_i & (~if_req_i | prio_ls_q);
    if_win = if_req_i & (~ls_req_i | ~prio_ls_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prio_ls_q <= 1'b1;
    end else if (if_gnt_o || ls_gnt_o) begin
      prio_ls_q <= if_gnt_o;
    end
  end
`else
  always_comb begin
    ls_win = ls_req_i;
    if_win = if_req_i & ~ls_req_i;
  end
`endif

  // Grants are combinational in IDLE and forced low while reset is asserted.
  assign if_gnt_o = rstn_i & (state_q == ST_IDLE) & if_win;
  assign ls_gnt_o = rstn_i & (state_q == ST_IDLE) & ls_win;

  assign txn_done = (state_q == ST_WAIT) & (we_q ? mc_wr_done_i : mc_rd_valid_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mc_rd_o        = 1'b0;
    mc_wr_o        = 1'b0;
    if_rsp_valid_o = 1'b0;
    ls_rsp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_gnt_o || ls_gnt_o) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        mc_rd_o = ~we_q;
        mc_wr_o = we_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (txn_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if_rsp_valid_o = ~owner_ls_q;
        ls_rsp_valid_o = owner_ls_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_ls_q    <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      if_rsp_data_q <= '0;
      ls_rsp_data_q <= '0;
    end else begin
      if (ls_gnt_o) begin
        owner_ls_q <= 1'b1;
        we_q       <= ls_we_i;
        addr_q     <= ls_addr_i;
        wdata_q    <= ls_wdata_i;
      end else if (if_gnt_o) begin
        owner_ls_q <= 1'b0;
        we_q       <= 1'b0;
        addr_q     <= if_addr_i;
        wdata_q    <= '0;
      end
      // Response data lands straight in the owner's register so it holds between pulses.
      if (txn_done) begin
        if (owner_ls_q) begin
          ls_rsp_data_q <= we_q ? '0 : mc_rd_data_i;
        end else begin
          if_rsp_data_q <= mc_rd_data_i;
        end
      end
    end
  end

  assign mc_raddr_o    = addr_q;
  assign mc_waddr_o    = addr_q;
  assign mc_wr_data_o  = wdata_q;
  assign if_rsp_data_o = if_rsp_data_q;
  assign ls_rsp_data_o = ls_rsp_data_q;

`ifndef SYNTHESIS
  a_single_cmd: assert property (@(posedge clk_i) disable iff (!rstn_i) !(mc_rd_o && mc_wr_o));
  a_single_gnt: assert property (@(posedge clk_i) disable iff (!rstn_i) !(if_gnt_o && ls_gnt_o));
  a_single_rsp: assert property (@(posedge clk_i) disable iff (!rstn_i) !(if_rsp_valid_o && ls_rsp_valid_o));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
// Build with or without MEM_ARB_ROUND_ROBIN_EN; the reference model follows the same macro.
module tb_mem_port_arbiter;

  localparam int RAM_WIDTH = 18;
  localparam int RAM_DEPTH = 1024;
  localparam int ADDR_W    = $clog2(RAM_DEPTH - 1);

  typedef struct {
    bit                   is_ls;
    bit                   we;
    logic [ADDR_W-1:0]    addr;
    logic [RAM_WIDTH-1:0] wdata;
    logic [RAM_WIDTH-1:0] data;
    int                   cyc;
  } rec_t;

  logic                 clk_i = 1'b0;
  logic                 rstn_i = 1'b0;
  logic                 if_req_i = 1'b0, ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [ADDR_W-1:0]    if_addr_i = '0, ls_addr_i = '0;
  logic [RAM_WIDTH-1:0] ls_wdata_i = '0, mc_rd_data_i = '0;
  logic                 mc_rd_valid_i = 1'b0, mc_wr_done_i = 1'b0;
  logic                 if_gnt_o, ls_gnt_o, if_rsp_valid_o, ls_rsp_valid_o, mc_rd_o, mc_wr_o;
  logic [RAM_WIDTH-1:0] if_rsp_data_o, ls_rsp_data_o, mc_wr_data_o;
  logic [ADDR_W-1:0]    mc_raddr_o, mc_waddr_o;

  mem_port_arbiter #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rsp_data_o(ls_rsp_data_o),
    .mc_rd_o(mc_rd_o), .mc_wr_o(mc_wr_o), .mc_raddr_o(mc_raddr_o), .mc_waddr_o(mc_waddr_o),
    .mc_wr_data_o(mc_wr_data_o), .mc_rd_data_i(mc_rd_data_i),
    .mc_rd_valid_i(mc_rd_valid_i), .mc_wr_done_i(mc_wr_done_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  logic [RAM_WIDTH-1:0] mc_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ref_mem[RAM_DEPTH];
  rec_t if_q[$], ls_q[$], exp_q[$];
  rec_t gnt_log[$], cmd_log[$], rsp_log[$];
  int   done_log[$];
  int   pend_cnt = 0;
  bit   pend_rd = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;
  bit   inflight = 1'b0;
  rec_t cur;
  int   hold_err = 0, both_cmd = 0, both_gnt = 0;
  bit   last_ls = 1'b0;

  function automatic rec_t mk(input bit is_ls, input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [RAM_WIDTH-1:0] wdata, input logic [RAM_WIDTH-1:0] data,
                              input int c);
    rec_t r;
    r.is_ls = is_ls; r.we = we; r.addr = addr; r.wdata = wdata; r.data = data; r.cyc = c;
    return r;
  endfunction

  // Reference: service order and response data straight from the arbitration rules.
  task automatic build_expected();
    rec_t iq[$], lq[$], r;
    bit pick_ls;
    iq = if_q; lq = ls_q; exp_q.delete();
    while (iq.size() > 0 || lq.size() > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (iq.size() > 0 && lq.size() > 0) pick_ls = !last_ls;
      else                                pick_ls = (lq.size() > 0);
`else
      pick_ls = (lq.size() > 0);
`endif
      r = pick_ls ? lq.pop_front() : iq.pop_front();
      r.is_ls = pick_ls;
      if (r.we) begin
        ref_mem[r.addr] = r.wdata;
        r.data = '0;
      end else begin
        r.data = ref_mem[r.addr];
      end
      last_ls = pick_ls;
      exp_q.push_back(r);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete(); cmd_log.delete(); rsp_log.delete(); done_log.delete();
    hold_err = 0; both_cmd = 0; both_gnt = 0;
  endtask

  // One clock: memctrl model, observation logging, requester agents.
  task automatic tick();
    rec_t r;
    @(negedge clk_i);
    cyc++;
    mc_rd_valid_i = 1'b0;
    mc_wr_done_i  = 1'b0;
    mc_rd_data_i  = RAM_WIDTH'($urandom);
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        if (pend_rd) begin
          mc_rd_valid_i = 1'b1;
          mc_rd_data_i  = mc_mem[pend_addr];
        end else begin
          mc_wr_done_i = 1'b1;
        end
        done_log.push_back(cyc);
      end else if ($urandom_range(0, 3) == 0) begin
        if (pend_rd) mc_wr_done_i = 1'b1;
        else         mc_rd_valid_i = 1'b1;
      end
    end
    if (inflight) begin
      if (mc_raddr_o !== cur.addr || mc_waddr_o !== cur.addr) hold_err++;
      if (cur.we && mc_wr_data_o !== cur.wdata) hold_err++;
    end
    if (mc_rd_o && mc_wr_o) both_cmd++;
    if (mc_rd_o || mc_wr_o) begin
      cmd_log.push_back(mk(1'b0, mc_wr_o, mc_wr_o ? mc_waddr_o : mc_raddr_o, mc_wr_data_o, '0, cyc));
      pend_cnt  = $urandom_range(1, 4);
      pend_rd   = mc_rd_o;
      pend_addr = mc_raddr_o;
      if (mc_wr_o) mc_mem[mc_waddr_o] = mc_wr_data_o;
    end
    if (if_rsp_valid_o) begin
      rsp_log.push_back(mk(1'b0, 1'b0, '0, '0, if_rsp_data_o, cyc));
      inflight = 1'b0;
    end
    if (ls_rsp_valid_o) begin
      rsp_log.push_back(mk(1'b1, 1'b0, '0, '0, ls_rsp_data_o, cyc));
      inflight = 1'b0;
    end
    if_req_i   = (if_q.size() > 0);
    if_addr_i  = if_req_i ? if_q[0].addr : ADDR_W'($urandom);
    ls_req_i   = (ls_q.size() > 0);
    ls_we_i    = ls_req_i ? ls_q[0].we : 1'($urandom);
    ls_addr_i  = ls_req_i ? ls_q[0].addr : ADDR_W'($urandom);
    ls_wdata_i = ls_req_i ? ls_q[0].wdata : RAM_WIDTH'($urandom);
    #1;
    if (if_gnt_o && ls_gnt_o) both_gnt++;
    if (ls_gnt_o || if_gnt_o) begin
      r = mk(ls_gnt_o, 1'b0, '0, '0, '0, cyc);
      gnt_log.push_back(r);
      if (ls_gnt_o && ls_q.size() > 0) cur = ls_q.pop_front();
      else if (!ls_gnt_o && if_q.size() > 0) cur = if_q.pop_front();
      inflight = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0;
    if_q.delete(); ls_q.delete();
    pend_cnt = 0; inflight = 1'b0; last_ls = 1'b0;
    repeat (2) tick();
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic run_txns(input int budget, output bit ok);
    int n = 0;
    while ((if_q.size() > 0 || ls_q.size() > 0 || inflight || pend_cnt > 0) && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
    tick();
  endtask

  task automatic test_reset();
    if_req_i = 1'b1; ls_req_i = 1'b1;
    #1;
    n_chk++; if ({if_gnt_o, ls_gnt_o, if_rsp_valid_o, ls_rsp_valid_o, mc_rd_o, mc_wr_o} !== 6'b0)
      $display("FAIL reset_ctrl: got %b exp 000000", {if_gnt_o, ls_gnt_o, if_rsp_valid_o, ls_rsp_valid_o, mc_rd_o, mc_wr_o});
    else n_pass++;
    n_chk++; if ({mc_raddr_o, mc_waddr_o, mc_wr_data_o} !== '0)
      $display("FAIL reset_addr: got %h/%h/%h exp 0", mc_raddr_o, mc_waddr_o, mc_wr_data_o);
    else n_pass++;
    n_chk++; if ({if_rsp_data_o, ls_rsp_data_o} !== '0)
      $display("FAIL reset_rdata: got %h/%h exp 0", if_rsp_data_o, ls_rsp_data_o);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_if_read();
    bit ok;
    clear_logs();
    mc_mem[5] = 18'h12345; ref_mem[5] = 18'h12345;
    if_q.push_back(mk(1'b0, 1'b0, 10'h005, '0, '0, 0));
    build_expected();
    run_txns(50, ok);
    n_chk++; if (!ok) $display("FAIL if_read_timeout: got timeout exp done"); else n_pass++;
    n_chk++; if (gnt_log.size() != 1 || cmd_log.size() != 1 || rsp_log.size() != 1)
      $display("FAIL if_read_counts: got %0d/%0d/%0d exp 1/1/1", gnt_log.size(), cmd_log.size(), rsp_log.size());
    else n_pass++;
    if (cmd_log.size() > 0 && gnt_log.size() > 0) begin
      n_chk++; if (cmd_log[0].we !== 1'b0 || cmd_log[0].addr !== 10'h005 || cmd_log[0].cyc != gnt_log[0].cyc + 1)
        $display("FAIL if_read_cmd: got we=%0d addr=%h cyc=%0d exp we=0 addr=005 cyc=%0d", cmd_log[0].we, cmd_log[0].addr, cmd_log[0].cyc, gnt_log[0].cyc + 1);
      else n_pass++;
    end
    if (rsp_log.size() > 0) begin
      n_chk++; if (rsp_log[0].is_ls !== 1'b0 || rsp_log[0].data !== 18'h12345)
        $display("FAIL if_read_rsp: got ls=%0d data=%h exp ls=0 data=12345", rsp_log[0].is_ls, rsp_log[0].data);
      else n_pass++;
    end
    n_chk++; if (hold_err != 0) $display("FAIL if_read_hold: got %0d errs exp 0", hold_err); else n_pass++;
  endtask

  task automatic test_ls_write_read();
    bit ok;
    clear_logs();
    ls_q.push_back(mk(1'b1, 1'b1, 10'h3FF, 18'h2AAAA, '0, 0));
    ls_q.push_back(mk(1'b1, 1'b0, 10'h3FF, '0, '0, 0));
    build_expected();
    run_txns(60, ok);
    n_chk++; if (!ok || cmd_log.size() != 2 || rsp_log.size() != 2 || done_log.size() != 2)
      $display("FAIL lswr_counts: got ok=%0d cmd=%0d rsp=%0d exp 1/2/2", ok, cmd_log.size(), rsp_log.size());
    else n_pass++;
    if (cmd_log.size() == 2 && rsp_log.size() == 2 && done_log.size() == 2) begin
      n_chk++; if (cmd_log[0].we !== 1'b1 || cmd_log[0].wdata !== 18'h2AAAA || cmd_log[1].we !== 1'b0)
        $display("FAIL lswr_cmds: got we0=%0d wd=%h we1=%0d exp 1/2aaaa/0", cmd_log[0].we, cmd_log[0].wdata, cmd_log[1].we);
      else n_pass++;
      n_chk++; if (rsp_log[0].cyc != done_log[0] + 1 || rsp_log[0].is_ls !== 1'b1 || rsp_log[0].data !== '0)
        $display("FAIL lswr_wr_rsp: got cyc=%0d data=%h exp cyc=%0d data=0", rsp_log[0].cyc, rsp_log[0].data, done_log[0] + 1);
      else n_pass++;
      n_chk++; if (rsp_log[1].data !== 18'h2AAAA)
        $display("FAIL lswr_rd_data: got %h exp 2aaaa", rsp_log[1].data);
      else n_pass++;
    end
    n_chk++; if (both_cmd != 0 || hold_err != 0)
      $display("FAIL lswr_cmd_excl: got both=%0d hold=%0d exp 0/0", both_cmd, hold_err);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    clear_logs();
    if_q.push_back(mk(1'b0, 1'b0, 10'h001, '0, '0, 0));
    ls_q.push_back(mk(1'b1, 1'b0, 10'h002, '0, '0, 0));
    build_expected();
    run_txns(60, ok);
    n_chk++; if (!ok || gnt_log.size() != 2 || cmd_log.size() != 2 || rsp_log.size() != 2)
      $display("FAIL cont_counts: got ok=%0d gnt=%0d cmd=%0d rsp=%0d exp 1/2/2/2", ok, gnt_log.size(), cmd_log.size(), rsp_log.size());
    else n_pass++;
    if (gnt_log.size() == 2 && rsp_log.size() == 2) begin
      n_chk++; if (gnt_log[0].is_ls !== 1'b1 || gnt_log[1].is_ls !== 1'b0)
        $display("FAIL cont_order: got %0d,%0d exp 1,0", gnt_log[0].is_ls, gnt_log[1].is_ls);
      else n_pass++;
      n_chk++; if (gnt_log[1].cyc != rsp_log[0].cyc + 1)
        $display("FAIL cont_regrant: got cyc %0d exp %0d", gnt_log[1].cyc, rsp_log[0].cyc + 1);
      else n_pass++;
      n_chk++; if (rsp_log[0].data !== exp_q[0].data || rsp_log[1].data !== exp_q[1].data)
        $display("FAIL cont_data: got %h,%h exp %h,%h", rsp_log[0].data, rsp_log[1].data, exp_q[0].data, exp_q[1].data);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      if_q.push_back(mk(1'b0, 1'b0, ADDR_W'(16 + i), '0, '0, 0));
      ls_q.push_back(mk(1'b1, 1'b0, ADDR_W'(32 + i), '0, '0, 0));
    end
    build_expected();
    run_txns(120, ok);
    n_chk++; if (!ok || gnt_log.size() != 6)
      $display("FAIL rr_counts: got ok=%0d gnt=%0d exp 1/6", ok, gnt_log.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) begin
        n_chk++; if (gnt_log[i].is_ls !== exp_q[i].is_ls)
          $display("FAIL rr_order[%0d]: got ls=%0d exp ls=%0d", i, gnt_log[i].is_ls, exp_q[i].is_ls);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    for (int i = 0; i < 4; i++) if_q.push_back(mk(1'b0, 1'b0, ADDR_W'(i), '0, '0, 0));
    build_expected();
    run_txns(80, ok);
    n_chk++; if (!ok || cmd_log.size() != 4 || rsp_log.size() != 4 || gnt_log.size() != 4)
      $display("FAIL b2b_counts: got ok=%0d cmd=%0d rsp=%0d exp 1/4/4", ok, cmd_log.size(), rsp_log.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_log.size() && i < cmd_log.size() && i < gnt_log.size()) begin
        n_chk++; if (rsp_log[i].data !== exp_q[i].data || cmd_log[i].addr !== ADDR_W'(i) || cmd_log[i].we !== 1'b0)
          $display("FAIL b2b[%0d]: got data=%h addr=%h exp data=%h addr=%h", i, rsp_log[i].data, cmd_log[i].addr, exp_q[i].data, i);
        else n_pass++;
        if (i > 0) begin
          n_chk++; if (gnt_log[i].cyc != rsp_log[i-1].cyc + 1)
            $display("FAIL b2b_gap[%0d]: got gnt cyc %0d exp %0d", i, gnt_log[i].cyc, rsp_log[i-1].cyc + 1);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int n = 0;
    clear_logs();
    ls_q.push_back(mk(1'b1, 1'b1, 10'h010, 18'h3FFFF, '0, 0));
    build_expected();
    while (cmd_log.size() == 0 && n < 20) begin tick(); n++; end
    n_chk++; if (cmd_log.size() != 1) $display("FAIL rst_wait_cmd: got %0d cmds exp 1", cmd_log.size()); else n_pass++;
    pend_cnt = 0;
    tick(); tick();
    #2 rstn_i = 1'b0;
    #1;
    n_chk++; if ({if_gnt_o, ls_gnt_o, if_rsp_valid_o, ls_rsp_valid_o, mc_rd_o, mc_wr_o} !== 6'b0 ||
                 {mc_raddr_o, mc_waddr_o, mc_wr_data_o, ls_rsp_data_o} !== '0)
      $display("FAIL rst_wait_outs: got ctl=%b addr=%h wd=%h exp 0", {if_gnt_o, ls_gnt_o, if_rsp_valid_o, ls_rsp_valid_o, mc_rd_o, mc_wr_o}, mc_raddr_o, mc_wr_data_o);
    else n_pass++;
    inflight = 1'b0; last_ls = 1'b0;
    @(posedge clk_i);
    #2 rstn_i = 1'b1;
    repeat (4) tick();
    n_chk++; if (rsp_log.size() != 0) $display("FAIL rst_wait_norsp: got %0d rsp exp 0", rsp_log.size()); else n_pass++;
    clear_logs();
    if_q.push_back(mk(1'b0, 1'b0, 10'h005, '0, '0, 0));
    build_expected();
    run_txns(50, ok);
    n_chk++; if (!ok || rsp_log.size() != 1 || rsp_log[0].data !== exp_q[0].data)
      $display("FAIL rst_wait_after: got ok=%0d rsp=%0d exp 1/1 data %h", ok, rsp_log.size(), exp_q[0].data);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int ni, nl;
    for (int it = 0; it < 20; it++) begin
      clear_logs();
      ni = $urandom_range(0, 5);
      nl = $urandom_range(0, 5);
      for (int i = 0; i < ni; i++) if_q.push_back(mk(1'b0, 1'b0, ADDR_W'($urandom_range(0, 15)), '0, '0, 0));
      for (int i = 0; i < nl; i++)
        ls_q.push_back(mk(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), RAM_WIDTH'($urandom), '0, 0));
      build_expected();
      run_txns(200, ok);
      n_chk++; if (!ok || gnt_log.size() != exp_q.size() || cmd_log.size() != exp_q.size() ||
                   rsp_log.size() != exp_q.size() || done_log.size() != exp_q.size())
        $display("FAIL rnd%0d_counts: got ok=%0d gnt=%0d cmd=%0d rsp=%0d exp %0d", it, ok, gnt_log.size(), cmd_log.size(), rsp_log.size(), exp_q.size());
      else n_pass++;
      n_chk++; if (hold_err != 0 || both_cmd != 0 || both_gnt != 0)
        $display("FAIL rnd%0d_excl: got hold=%0d bcmd=%0d bgnt=%0d exp 0", it, hold_err, both_cmd, both_gnt);
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i < gnt_log.size() && i < cmd_log.size() && i < rsp_log.size() && i < done_log.size()) begin
          n_chk++; if (gnt_log[i].is_ls !== exp_q[i].is_ls || rsp_log[i].is_ls !== exp_q[i].is_ls)
            $display("FAIL rnd%0d_owner[%0d]: got gnt=%0d rsp=%0d exp %0d", it, i, gnt_log[i].is_ls, rsp_log[i].is_ls, exp_q[i].is_ls);
          else n_pass++;
          n_chk++; if (cmd_log[i].we !== exp_q[i].we || cmd_log[i].addr !== exp_q[i].addr ||
                       (exp_q[i].we && cmd_log[i].wdata !== exp_q[i].wdata) || cmd_log[i].cyc != gnt_log[i].cyc + 1)
            $display("FAIL rnd%0d_cmd[%0d]: got we=%0d a=%h d=%h c=%0d exp we=%0d a=%h d=%h c=%0d", it, i,
                     cmd_log[i].we, cmd_log[i].addr, cmd_log[i].wdata, cmd_log[i].cyc,
                     exp_q[i].we, exp_q[i].addr, exp_q[i].wdata, gnt_log[i].cyc + 1);
          else n_pass++;
          n_chk++; if (rsp_log[i].data !== exp_q[i].data || rsp_log[i].cyc != done_log[i] + 1)
            $display("FAIL rnd%0d_rsp[%0d]: got d=%h c=%0d exp d=%h c=%0d", it, i, rsp_log[i].data, rsp_log[i].cyc, exp_q[i].data, done_log[i] + 1);
          else n_pass++;
          if (i > 0) begin
            n_chk++; if (gnt_log[i].cyc != rsp_log[i-1].cyc + 1)
              $display("FAIL rnd%0d_gap[%0d]: got %0d exp %0d", it, i, gnt_log[i].cyc, rsp_log[i-1].cyc + 1);
            else n_pass++;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      mc_mem[i]  = RAM_WIDTH'($urandom);
      ref_mem[i] = mc_mem[i];
    end
    test_reset();
    test_if_read();
    test_reset_mid_wait();
    test_ls_write_read();
    test_contention();
    test_round_robin();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
